// File: rtl/video_binning_2x2_pkg.sv
// Package binning_2x2_pkg: shared constants and width helpers for the
// 2x2 binning block.
//   LAT    : clocks from the de_i of the 2nd pixel of an odd-line pair to de_o
//   pair_w : width of a horizontal pair sum
//   sum_w  : width of a full 2x2 block sum
//   addr_w : line buffer address width for a given max line size
package binning_2x2_pkg;

    localparam int LAT = 3;

    function automatic int pair_w(input int pw);
        return pw + 1;
    endfunction

    function automatic int sum_w(input int pw);
        return pw + 2;
    endfunction

    function automatic int addr_w(input int line_size_max);
        return (line_size_max / 2 > 1) ? $clog2(line_size_max / 2) : 1;
    endfunction

endpackage

// File: rtl/video_binning_2x2_if.sv
// Video stream interface for video_binning_2x2.
//   di_i/de_i/hs_i/vs_i : sync-qualified input stream (into the binning block)
//   do_o/de_o/hs_o/vs_o : binned output stream (out of the binning block)
// Modports:
//   slave  : the binning block side (consumes inputs, drives outputs)
//   master : the source/sink side (drives inputs, observes outputs)
interface video_binning_2x2_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0] di_i;
    logic                   de_i;
    logic                   hs_i;
    logic                   vs_i;
    logic [PIXEL_WIDTH-1:0] do_o;
    logic                   de_o;
    logic                   hs_o;
    logic                   vs_o;

    modport slave  (input  di_i, de_i, hs_i, vs_i, output do_o, de_o, hs_o, vs_o);
    modport master (output di_i, de_i, hs_i, vs_i, input  do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/video_binning_2x2_linebuf.sv
// binning_2x2_linebuf: simple dual-port line buffer holding the horizontal
// pair sums of the previous (even) line.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address (pair index)
//   wdata_i : pair sum to store
//   raddr_i : read address (pair index)
//   rdata_o : read data, one clock after raddr_i
// Contents are not reset.
module binning_2x2_linebuf #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 9,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/video_binning_2x2.sv
// video_binning_2x2: streaming 2x2 pixel binning (mean of each 2x2 block).
// Output frame is W/2 x H/2; unpaired last column/row are dropped.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   bypass : pass input through at the same latency (sampled while vs_i=0)
//   vif    : video stream (slave modport): di_i/de_i/hs_i/vs_i in,
//            do_o/de_o/hs_o/vs_o out, all delayed by LAT clocks
// Configuration macro:
//   BINNING_2X2_ROUND_EN : round half up instead of truncating the mean
import binning_2x2_pkg::*;

module video_binning_2x2 #(
    parameter int DE_SPARSE     = 0,
    parameter int LINE_SIZE_MAX = 4096,
    parameter int PIXEL_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bypass,
    video_binning_2x2_if.slave  vif
);
    localparam int PW     = PIXEL_WIDTH;
    localparam int PAIR_W = pair_w(PIXEL_WIDTH);
    localparam int SUM_W  = sum_w(PIXEL_WIDTH);
    localparam int DEPTH  = LINE_SIZE_MAX / 2;
    localparam int AW     = addr_w(LINE_SIZE_MAX);

`ifdef BINNING_2X2_ROUND_EN
    localparam logic [SUM_W-1:0] RND = SUM_W'(2);
`else
    localparam logic [SUM_W-1:0] RND = '0;
`endif

    // Port timing does not depend on input sparsity; only sanity-check it.
    if (DE_SPARSE < 0) begin : g_bad_sparse
        $error("DE_SPARSE must be >= 0");
    end

    // Parity / position state
    logic          px_q, px_d;
    logic          ln_q, ln_d;
    logic          hs_prev_q, hs_prev_d;
    logic          byp_q, byp_d;
    logic          run_q, run_d;
    logic [PW-1:0] prev_q, prev_d;
    logic [AW-1:0] addr_q, addr_d;

    // Pipeline state
    logic [LAT:1]      vld_pipe_q;
    logic              s1_byp_q;
    logic [PAIR_W-1:0] s1_data_q;
    logic [PW-1:0]     s2_pix_q;
    logic [PW-1:0]     do_q;
    logic [LAT-1:0]    hs_pipe_q;
    logic [LAT-1:0]    vs_pipe_q;

    logic [PAIR_W-1:0] pair;
    logic [PAIR_W-1:0] buf_rdata;
    logic [SUM_W-1:0]  sum_r;
    logic              pair_ok;
    logic              buf_we;
    logic              v0;

    always_comb begin
        px_d      = px_q;
        ln_d      = ln_q;
        byp_d     = byp_q;
        run_d     = run_q;
        prev_d    = prev_q;
        addr_d    = addr_q;
        hs_prev_d = vif.hs_i;
        // Outside a frame: clear line parity, latch bypass, and re-arm after a reset.
        if (!vif.vs_i) begin
            ln_d  = 1'b0;
            byp_d = bypass;
            run_d = 1'b1;
        end else if (vif.hs_i && !hs_prev_q) begin
            ln_d = ~ln_q;
        end
        if (vif.hs_i) begin
            px_d   = 1'b0;
            addr_d = '0;
        end else if (vif.de_i) begin
            px_d   = ~px_q;
            prev_d = vif.di_i;
            if (px_q) addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
        end
    end

    always_comb begin
        pair    = {1'b0, prev_q} + {1'b0, vif.di_i};
        // run_q stays low from a mid-frame reset until the next frame starts.
        pair_ok = vif.de_i & px_q & run_q & ~byp_q;
        buf_we  = pair_ok & ~ln_q;
        v0      = byp_q ? (vif.de_i & run_q) : (pair_ok & ln_q);
        sum_r   = {1'b0, buf_rdata} + {1'b0, s1_data_q} + RND;
    end

    binning_2x2_linebuf #(
        .DEPTH (DEPTH),
        .WIDTH (PAIR_W),
        .AW    (AW)
    ) u_linebuf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (addr_q),
        .wdata_i (pair),
        .raddr_i (addr_q),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            px_q       <= 1'b0;
            ln_q       <= 1'b0;
            hs_prev_q  <= 1'b1;
            byp_q      <= 1'b0;
            run_q      <= 1'b0;
            prev_q     <= '0;
            addr_q     <= '0;
            vld_pipe_q <= '0;
            s1_byp_q   <= 1'b0;
            s1_data_q  <= '0;
            s2_pix_q   <= '0;
            do_q       <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '0;
        end else begin
            px_q       <= px_d;
            ln_q       <= ln_d;
            hs_prev_q  <= hs_prev_d;
            byp_q      <= byp_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            addr_q     <= addr_d;
            vld_pipe_q <= {vld_pipe_q[LAT-1:1], v0};
            // Stage 1 carries either the pair sum or the raw pixel (bypass).
            s1_byp_q   <= byp_q;
            s1_data_q  <= byp_q ? {1'b0, vif.di_i} : pair;
            // Stage 2: combine with the buffered even-line pair; >>2 of a full-scale
            // sum is full scale, so no saturation is needed.
            s2_pix_q   <= s1_byp_q ? s1_data_q[PW-1:0] : PW'(sum_r >> 2);
            do_q       <= s2_pix_q;
            hs_pipe_q  <= {hs_pipe_q[LAT-2:0], vif.hs_i};
            vs_pipe_q  <= {vs_pipe_q[LAT-2:0], vif.vs_i};
        end
    end

    assign vif.do_o = do_q;
    assign vif.de_o = vld_pipe_q[LAT];
    assign vif.hs_o = hs_pipe_q[LAT-1];
    assign vif.vs_o = vs_pipe_q[LAT-1];
endmodule

// File: tb/tb_video_binning_2x2.sv
// Scoreboard bench for video_binning_2x2: the driver pushes the expected
// output pixel for every pair it completes; a negedge monitor pops and
// compares on each de_o and checks hs_o/vs_o against a 3-deep input history.
module tb_video_binning_2x2;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bypass = 1'b0;

    video_binning_2x2_if #(.PIXEL_WIDTH(PW)) vif();

    video_binning_2x2 #(
        .DE_SPARSE     (0),
        .LINE_SIZE_MAX (64),
        .PIXEL_WIDTH   (PW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bypass (bypass),
        .vif    (vif)
    );

    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_pass = 0;
    logic [PW-1:0] exp_q[$];
    bit            chk_sync = 1'b0;
    int            hist_n   = 0;
    logic [2:0]    h_hs = '1;
    logic [2:0]    h_vs = '0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (vif.de_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected de_o: queue empty, do_o=%0d", vif.do_o);
            end else begin
                check("pixel", int'(vif.do_o), int'(exp_q.pop_front()));
            end
        end
        if (chk_sync && hist_n >= 3) begin
            check("hs_o delay", int'(vif.hs_o), int'(h_hs[2]));
            check("vs_o delay", int'(vif.vs_o), int'(h_vs[2]));
        end
        h_hs   = {h_hs[1:0], vif.hs_i};
        h_vs   = {h_vs[1:0], vif.vs_i};
        hist_n = chk_sync ? hist_n + 1 : 0;
    end

    // mode 0: ramp di=x, 1: const 255, 2: const 0, 3: mixed pattern
    function automatic int pix(input int mode, input int x, input int y);
        case (mode)
            0:       return x & 255;
            1:       return 255;
            2:       return 0;
            default: return (x * 7 + y * 13) & 255;
        endcase
    endfunction

    // Expected binned value for the block whose bottom-right pixel is (x,y).
    function automatic int expv(input int mode, input int x, input int y);
        int s;
        if (mode == 0) begin
            // ramp: block sum 8k+2 with k = x/2
`ifdef BINNING_2X2_ROUND_EN
            return 2 * (x / 2) + 1;
`else
            return 2 * (x / 2);
`endif
        end
        s = pix(mode, x - 1, y - 1) + pix(mode, x, y - 1) + pix(mode, x - 1, y) + pix(mode, x, y);
`ifdef BINNING_2X2_ROUND_EN
        s += 2;
`endif
        return s >> 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int y, input int w, input int mode,
                              input bit sparse, input bit byp, input bit push);
        vif.hs_i = 1'b0;
        for (int x = 0; x < w; x++) begin
            vif.de_i = 1'b1;
            vif.di_i = PW'(pix(mode, x, y));
            if (push) begin
                if (byp) exp_q.push_back(PW'(pix(mode, x, y)));
                else if ((x % 2 == 1) && (y % 2 == 1)) exp_q.push_back(PW'(expv(mode, x, y)));
            end
            tick();
            if (sparse) begin
                vif.de_i = 1'b0;
                tick();
            end
        end
        vif.de_i = 1'b0;
        vif.hs_i = 1'b1;
        repeat (3) tick();
    endtask

    task automatic drive_frame(input int w, input int h, input int mode,
                               input bit sparse, input bit byp, input bit flip);
        vif.vs_i = 1'b0;
        vif.hs_i = 1'b1;
        vif.de_i = 1'b0;
        repeat (4) tick();
        vif.vs_i = 1'b1;
        repeat (2) tick();
        for (int y = 0; y < h; y++) begin
            if (flip && y == 2) bypass = ~bypass;
            drive_line(y, w, mode, sparse, byp, 1'b1);
        end
        if (flip) bypass = ~bypass;
        vif.vs_i = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        vif.di_i = '0;
        vif.de_i = 1'b0;
        vif.hs_i = 1'b1;
        vif.vs_i = 1'b0;
        rst      = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("reset do_o", int'(vif.do_o), 0);
        check("reset de_o", int'(vif.de_o), 0);
        check("reset hs_o", int'(vif.hs_o), 1);
        check("reset vs_o", int'(vif.vs_o), 0);
        rst = 1'b0;
        tick();
        chk_sync = 1'b1;

        drive_frame(24, 24, 0, 1'b0, 1'b0, 1'b0);   // ramp, 2 frames
        drive_frame(24, 24, 0, 1'b0, 1'b0, 1'b0);
        drive_frame(16, 8, 1, 1'b0, 1'b0, 1'b0);    // full scale
        drive_frame(16, 8, 2, 1'b0, 1'b0, 1'b0);    // zero
        drive_frame(24, 24, 0, 1'b1, 1'b0, 1'b0);   // sparse ramp
        drive_frame(25, 25, 0, 1'b0, 1'b0, 1'b0);   // odd size
        drive_frame(20, 10, 3, 1'b0, 1'b0, 1'b1);   // pattern, bypass toggled mid-frame
        bypass = 1'b1;
        drive_frame(10, 6, 3, 1'b0, 1'b1, 1'b0);    // bypass
        bypass = 1'b0;
        drive_frame(12, 4, 3, 1'b0, 1'b0, 1'b0);    // back to binning

        // Mid-frame reset during an even line, with sync outputs mid-frame.
        chk_sync = 1'b0;
        vif.vs_i = 1'b0;
        vif.hs_i = 1'b1;
        repeat (4) tick();
        vif.vs_i = 1'b1;
        repeat (2) tick();
        for (int y = 0; y < 4; y++) drive_line(y, 24, 0, 1'b0, 1'b0, 1'b1);
        vif.hs_i = 1'b0;
        for (int x = 0; x < 10; x++) begin
            vif.de_i = 1'b1;
            vif.di_i = PW'(x);
            tick();
        end
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mid rst de_o", int'(vif.de_o), 0);
        check("mid rst hs_o", int'(vif.hs_o), 1);
        check("mid rst vs_o", int'(vif.vs_o), 0);
        check("mid rst do_o", int'(vif.do_o), 0);
        rst = 1'b0;
        tick();
        for (int x = 10; x < 24; x++) begin
            vif.de_i = 1'b1;
            vif.di_i = PW'(x);
            tick();
        end
        vif.de_i = 1'b0;
        vif.hs_i = 1'b1;
        repeat (3) tick();
        // Remaining lines of the interrupted frame must produce nothing.
        for (int y = 5; y < 8; y++) drive_line(y, 24, 0, 1'b0, 1'b0, 1'b0);
        vif.vs_i = 1'b0;
        tick();
        chk_sync = 1'b1;
        drive_frame(24, 24, 0, 1'b0, 1'b0, 1'b0);   // clean frame after reset

        repeat (10) tick();
        check("queue drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
